// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, ISA field encodings and datapath control constants
package cpu_pkg;
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_HALT
  } state_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
  localparam logic [1:0] VSEL_PC = 2'b10;
  localparam logic [1:0] VSEL_C = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;
endpackage

// File: rtl/instr_dec.sv
// instr_dec: splits the instruction register into fields and sign-extended immediates
module instr_dec #(
  parameter int IR_W = 16,
  parameter int RN_W = 3
) (
  input  logic [IR_W-1:0] ir,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [RN_W-1:0] rn,
  output logic [RN_W-1:0] rd,
  output logic [RN_W-1:0] rm,
  output logic [1:0]      sh,
  output logic [IR_W-1:0] sximm8,
  output logic [IR_W-1:0] sximm5
);
  assign opcode = ir[15:13];
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign sximm8 = {{(IR_W-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(IR_W-5){ir[4]}}, ir[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore control FSM driving the 16-bit datapath
// Optional CPU_CTRL_ILLEGAL_EN: unsupported encodings trap in a sticky HALT state with illegal=1.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int IR_W = 16,
  parameter int RN_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] in,
  input  logic            load,
  input  logic            s,
  output logic            w,
  output logic [RN_W-1:0] readnum,
  output logic [RN_W-1:0] writenum,
  output logic            write,
  output logic            loada,
  output logic            loadb,
  output logic            asel,
  output logic            bsel,
  output logic [1:0]      shift,
  output logic [1:0]      ALUop,
  output logic            loadc,
  output logic            loads,
  output logic [1:0]      vsel,
  output logic [IR_W-1:0] sximm8,
  output logic [IR_W-1:0] sximm5
`ifdef CPU_CTRL_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);
  state_t state, next;
  logic [IR_W-1:0] ir;
  logic [2:0] opcode;
  logic [1:0] op, sh;
  logic [RN_W-1:0] rn, rd, rm;
  logic is_movi, is_movr, is_alu, is_cmp, is_unary;
  instr_dec #(.IR_W(IR_W), .RN_W(RN_W)) u_dec (
    .ir(ir), .opcode(opcode), .op(op), .rn(rn), .rd(rd), .rm(rm), .sh(sh),
    .sximm8(sximm8), .sximm5(sximm5)
  );
  assign is_movi = opcode == OPC_MOV && op == OP_MOVI;
  assign is_movr = opcode == OPC_MOV && op == OP_MOVR;
  assign is_alu = opcode == OPC_ALU;
  assign is_cmp = is_alu && op == OP_CMP;
  assign is_unary = is_movr || (is_alu && op == ALU_NOT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_WAIT;
      ir <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && load) ir <= in;
    end
  always_comb begin
    next = state;
    w = 1'b0;
    readnum = '0;
    writenum = '0;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    shift = 2'b00;
    ALUop = ALU_ADD;
    loadc = 1'b0;
    loads = 1'b0;
    vsel = VSEL_MDATA;
`ifdef CPU_CTRL_ILLEGAL_EN
    illegal = 1'b0;
`endif
    case (state)
      S_WAIT: begin
        w = 1'b1;
        next = s ? S_DECODE : S_WAIT;
      end
      S_DECODE:
        next = is_movi ? S_WRITE_IMM : (is_alu && !is_unary) ? S_GET_A : is_unary ? S_GET_B :
`ifdef CPU_CTRL_ILLEGAL_EN
               S_HALT;
`else
               S_WAIT;
`endif
      S_WRITE_IMM: begin
        writenum = rn;
        vsel = VSEL_SXIMM8;
        write = 1'b1;
        next = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada = 1'b1;
        next = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb = 1'b1;
        next = S_ALU;
      end
      S_ALU: begin
        shift = sh;
        asel = is_unary;
        ALUop = is_movr ? ALU_ADD : op;
        loadc = !is_cmp;
        loads = is_cmp;
        next = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel = VSEL_C;
        write = 1'b1;
        next = S_WAIT;
      end
      S_HALT: begin
`ifdef CPU_CTRL_ILLEGAL_EN
        illegal = 1'b1;
`else
        next = S_WAIT;
`endif
      end
      default: next = S_WAIT;
    endcase
  end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: table-driven instruction runs checked through an expectation queue, plus reset/back-to-back/illegal sequences
module tb_cpu_controller;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, s = 1'b0;
  logic [15:0] in = '0;
  logic w, write, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop, vsel;
  logic [15:0] sximm8, sximm5;
`ifdef CPU_CTRL_ILLEGAL_EN
  logic illegal;
`endif
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5)
`ifdef CPU_CTRL_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );
  typedef struct {
    logic [15:0] ins;
    int lat, nw;
    logic [2:0] wn;
    logic [1:0] vs;
    int na;
    logic [2:0] ra;
    int nb;
    logic [2:0] rb;
    int nc, ns;
    logic [1:0] op;
    logic as;
    logic [1:0] sh;
    logic [15:0] x8, x5;
  } vec_t;
  vec_t tab[7];
  vec_t sb[$];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    vec_t o, e;
    int nbsel = 0;
    o = '{v.ins, 0, 0, 3'd0, 2'd0, 0, 3'd0, 0, 3'd0, 0, 0, 2'd0, 1'b0, 2'd0, 16'h0, 16'h0};
    sb.push_back(v);
    @(negedge clk);
    in = v.ins;
    load = 1'b1;
    s = 1'b1;
    @(posedge clk);
    #1 s = 1'b0;
    in = ~v.ins;
    o.lat = 1;
    forever begin
      @(negedge clk);
      if (w || o.lat > 20) break;
      if (write) begin o.nw++; o.wn = writenum; o.vs = vsel; end
      if (loada) begin o.na++; o.ra = readnum; end
      if (loadb) begin o.nb++; o.rb = readnum; end
      if (loadc) o.nc++;
      if (loads) o.ns++;
      if (loadc || loads) begin o.op = ALUop; o.as = asel; o.sh = shift; end
      if (bsel) nbsel++;
      @(posedge clk);
      o.lat++;
    end
    load = 1'b0;
    o.x8 = sximm8;
    o.x5 = sximm5;
    e = sb.pop_front();
    chk($sformatf("%h latency", e.ins), 16'(o.lat), 16'(e.lat));
    chk($sformatf("%h write pulses", e.ins), 16'(o.nw), 16'(e.nw));
    if (e.nw > 0) begin
      chk($sformatf("%h writenum", e.ins), 16'(o.wn), 16'(e.wn));
      chk($sformatf("%h vsel", e.ins), 16'(o.vs), 16'(e.vs));
    end
    chk($sformatf("%h loada pulses", e.ins), 16'(o.na), 16'(e.na));
    if (e.na > 0) chk($sformatf("%h readnum A", e.ins), 16'(o.ra), 16'(e.ra));
    chk($sformatf("%h loadb pulses", e.ins), 16'(o.nb), 16'(e.nb));
    if (e.nb > 0) chk($sformatf("%h readnum B", e.ins), 16'(o.rb), 16'(e.rb));
    chk($sformatf("%h loadc pulses", e.ins), 16'(o.nc), 16'(e.nc));
    chk($sformatf("%h loads pulses", e.ins), 16'(o.ns), 16'(e.ns));
    if (e.nc + e.ns > 0) begin
      chk($sformatf("%h ALUop", e.ins), 16'(o.op), 16'(e.op));
      chk($sformatf("%h asel", e.ins), 16'(o.as), 16'(e.as));
      chk($sformatf("%h shift", e.ins), 16'(o.sh), 16'(e.sh));
    end
    chk($sformatf("%h bsel cycles", e.ins), 16'(nbsel), 16'd0);
    chk($sformatf("%h sximm8 (IR held)", e.ins), o.x8, e.x8);
    chk($sformatf("%h sximm5 (IR held)", e.ins), o.x5, e.x5);
  endtask
  initial begin
    int nw_hi, nwr;
    tab[0] = '{16'hD042, 3, 1, 3'd0, 2'b01, 0, 3'd0, 0, 3'd0, 0, 0, 2'b00, 1'b0, 2'b00, 16'h0042, 16'h0002};
    tab[1] = '{16'hD1FD, 3, 1, 3'd1, 2'b01, 0, 3'd0, 0, 3'd0, 0, 0, 2'b00, 1'b0, 2'b00, 16'hFFFD, 16'hFFFD};
    tab[2] = '{16'hA140, 6, 1, 3'd2, 2'b11, 1, 3'd1, 1, 3'd0, 1, 0, 2'b00, 1'b0, 2'b00, 16'h0040, 16'h0000};
    tab[3] = '{16'hA801, 5, 0, 3'd0, 2'b00, 1, 3'd0, 1, 3'd1, 0, 1, 2'b01, 1'b0, 2'b00, 16'h0001, 16'h0001};
    tab[4] = '{16'hB868, 5, 1, 3'd3, 2'b11, 0, 3'd0, 1, 3'd0, 1, 0, 2'b11, 1'b1, 2'b01, 16'h0068, 16'h0008};
    tab[5] = '{16'hB596, 6, 1, 3'd4, 2'b11, 1, 3'd5, 1, 3'd6, 1, 0, 2'b10, 1'b0, 2'b10, 16'hFF96, 16'hFFF6};
    tab[6] = '{16'hC0FA, 5, 1, 3'd7, 2'b11, 0, 3'd0, 1, 3'd2, 1, 0, 2'b00, 1'b1, 2'b11, 16'hFFFA, 16'hFFFA};
    #1;
    chk("reset w", 16'(w), 16'd1);
    chk("reset write", 16'(write), 16'd0);
    chk("reset enables", {12'd0, loada, loadb, loadc, loads}, 16'd0);
    chk("reset selects", {6'd0, readnum, writenum, vsel, ALUop}, 16'd0);
    chk("reset sximm8", sximm8, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) run(tab[i]);
    // back-to-back ADD with s held high: w high exactly one cycle per instruction
    @(negedge clk);
    in = 16'hA140;
    load = 1'b1;
    s = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    nw_hi = 0;
    nwr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      nw_hi += int'(w);
      nwr += int'(write);
    end
    chk("b2b w cycles", 16'(nw_hi), 16'd2);
    chk("b2b write pulses", 16'(nwr), 16'd2);
    chk("b2b w at sixth", 16'(w), 16'd1);
    s = 1'b0;
    repeat (8) @(negedge clk);
    chk("b2b idle", 16'(w), 16'd1);
    // reset during GET_B of ADD
    in = 16'hA140;
    load = 1'b1;
    s = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    s = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midop loadb", 16'(loadb), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midop reset w", 16'(w), 16'd1);
    chk("midop reset write/loadc/loadb", {13'd0, write, loadc, loadb}, 16'd0);
    chk("midop reset IR", sximm8, 16'd0);
    nwr = 0;
    repeat (3) begin
      @(posedge clk);
      #1 nwr += int'(write) + int'(loadc) + int'(loada) + int'(loadb);
    end
    chk("midop no pulses", 16'(nwr), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // unsupported opcode 111
    in = 16'hE000;
    load = 1'b1;
    s = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    s = 1'b0;
    repeat (2) @(negedge clk);
`ifdef CPU_CTRL_ILLEGAL_EN
    chk("illegal halt w", 16'(w), 16'd0);
    chk("illegal flag", 16'(illegal), 16'd1);
    s = 1'b1;
    repeat (5) @(negedge clk);
    chk("illegal sticky", {14'd0, illegal, w}, 16'd2);
    s = 1'b0;
    rst_n = 1'b0;
    #1 chk("illegal reset", {14'd0, illegal, w}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
`else
    chk("illegal returns to wait", 16'(w), 16'd1);
    chk("illegal no write", 16'(write), 16'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Instruction register, decoder and Moore control FSM that sits directly upstream of the 16-bit datapath. It latches a 16-bit instruction and decodes the register fields and sign-extended immediates. After a start strobe it sequences the datapath control lines (readnum, writenum, write, loada, loadb, asel, bsel, shift, ALUop, loadc, loads, vsel) over multiple cycles. It raises w when idle and ready for the next instruction.

Parameters:
- IR_W, 16, instruction and datapath word width (fixed ISA encoding; other values unsupported)
- RN_W, 3, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in  in  16  instruction word
- load  in  1  latch in into IR; honoured only in WAIT
- s  in  1  start; level-sampled in WAIT
- w  out  1  1 while in WAIT
- readnum  out  3  register-file read index
- writenum  out  3  register-file write index
- write  out  1  register-file write enable
- loada, loadb  out  1 each  A/B register enables
- asel, bsel  out  1 each  operand selects (asel=1 → A operand is 0; bsel=1 → B operand is sximm5)
- shift  out  2  shifter control
- ALUop  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
- loadc, loads  out  1 each  C and status register enables
- vsel  out  2  00 mdata, 01 sximm8, 10 PC, 11 C
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Supported instructions:
  - 110/10 MOV Rn,#im8
  - 110/00 MOV Rd,Rm{,sh}
  - 101/00 ADD Rd,Rn,Rm{,sh}
  - 101/01 CMP Rn,Rm{,sh}
  - 101/10 AND Rd,Rn,Rm{,sh}
  - 101/11 MVN Rd,Rm{,sh}
- Reset (async, any state): state=WAIT, IR=0. Every output is in its WAIT value: w=1, all enables 0, readnum=writenum=0, asel=bsel=0, shift=0, ALUop=0, vsel=0. sximm8=sximm5=0.
- Outputs are a pure Moore decode of state+IR. Any control line not listed for a state is 0.
- sximm8 and sximm5 are combinational from IR and valid in every state.
- WAIT: w=1. load=1 at an edge updates IR. s=1 at an edge moves to DECODE. If load and s are both 1 at the same edge, IR updates and DECODE uses the new IR.
- DECODE (all outputs idle), next state:
  - MOV imm → WRITE_IMM
  - ADD, CMP, AND → GET_A
  - MOV reg, MVN → GET_B
  - anything else → WAIT
- WRITE_IMM: writenum=Rn, vsel=01, write=1 → WAIT.
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → ALU.
- ALU: shift=sh, bsel=0, loadc=1.
  - asel=1 for MOV reg and MVN; 0 otherwise.
  - ALUop=00 for MOV reg; otherwise ALUop=op.
  - CMP: loadc=0, loads=1, next state WAIT. All others: next state WRITE_REG.
- WRITE_REG: writenum=Rd, vsel=11, write=1 → WAIT.
- Latency in edges from the s-sampling edge until w=1:
  - MOV imm: 3
  - MOV reg, MVN: 5
  - CMP: 5
  - ADD, AND: 6
- load outside WAIT is ignored and IR is held stable.
- s held high continuously re-executes the same IR back to back. In that case w is high for exactly one cycle between instructions.
- Reset asserted mid-instruction aborts immediately. No further write or load pulse may occur after rst_n falls.

Optional Feature:
- Macro: CPU_CTRL_ILLEGAL_EN.
- Defined: adds output illegal (1 bit, reset 0). DECODE on an unsupported opcode/op goes to a sticky HALT state: w=0, illegal=1, all enables 0. Only rst_n exits HALT.
- Undefined: no port. Unsupported encodings return DECODE → WAIT with no side effects.

Decomposition:
- Package cpu_pkg holds:
  - state enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG, HALT)
  - opcode/op localparams
  - VSEL_MDATA/SXIMM8/PC/C constants
  - ALU op constants
- One combinational sub-module, instr_dec: IR → opcode, op, Rn, Rd, Rm, sh, sximm8, sximm5. The FSM stays in cpu_controller.

Test Plan:
- MOV R0,#0x42 (in=16'hD042), load then s: DECODE, then WRITE_IMM with writenum=0, vsel=01, sximm8=16'h0042, write=1. w=1 after 3 edges.
- MOV R1,#-3 (16'hD1FD): sximm8=16'hFFFD, writenum=1, write pulses exactly one cycle.
- ADD R2,R1,R0 (16'hA140): GET_A readnum=1 loada=1; GET_B readnum=0 loadb=1; ALU ALUop=00 loadc=1 loads=0; WRITE_REG writenum=2 vsel=11. w after 6 edges.
- CMP R0,R1 (16'hA801): ALU state has loads=1, ALUop=01, loadc=0. No write pulse. w after 5 edges.
- MVN R3,R0,LSL#1 (16'hB868): GET_A skipped; ALU has asel=1, shift=01, ALUop=11; writenum=3. A load of a new word during execution leaves IR unchanged.
- Reset mid-op: assert rst_n=0 in GET_B of ADD → immediately w=1, write=loadc=0, IR=0. Opcode 111 (16'hE000): back to WAIT, or HALT with illegal=1 under CPU_CTRL_ILLEGAL_EN.
